// File: rtl/pc_adder_1_pkg.sv
// Shared types and constants for the fetch-stage program-counter incrementer.
// Build option: PC_ADDER_1_REG_OUT_EN (see pc_adder_1.sv).
package pc_adder_pkg;

  localparam int PC_WIDTH = 16;
  localparam int PC_STEP  = 1;

  typedef logic [PC_WIDTH-1:0] pc_t;

  localparam pc_t PC_RESET = '0;

endpackage

// File: rtl/pc_adder_1_if.sv
// Bus bundle between the fetch stage and the PC incrementer.
// The master drives the current PC and the sticky-flag clear.
// The slave (the incrementer) returns the next PC and the wrap status.
interface pc_adder_1_if
  import pc_adder_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
);

  logic [WIDTH-1:0] pcIn;
  logic [WIDTH-1:0] pcOut;
  logic             wrap;
  logic             wrap_seen;
  logic             clr_wrap;

  modport master (
    output pcIn,
    output clr_wrap,
    input  pcOut,
    input  wrap,
    input  wrap_seen
  );

  modport slave (
    input  pcIn,
    input  clr_wrap,
    output pcOut,
    output wrap,
    output wrap_seen
  );

endinterface

// File: rtl/pc_adder_1_core.sv
// Pure combinational WIDTH-bit adder of a constant STEP, with carry-out.
// The sum is formed one bit wider than the PC so the carry falls out as the MSB.
module pc_adder_1_core
  import pc_adder_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int STEP  = PC_STEP
) (
  input  logic [WIDTH-1:0] pcIn_i,
  output logic [WIDTH-1:0] pcOut_o,
  output logic             wrap_o
);

  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  logic [WIDTH:0] sumWide;

  // Widened add so the carry-out lands in the top bit; the low bits wrap modulo 2^WIDTH.
  assign sumWide = {1'b0, pcIn_i} + STEP_EXT;
  assign pcOut_o = sumWide[WIDTH-1:0];
  assign wrap_o  = sumWide[WIDTH];

endmodule

// File: rtl/pc_adder_1.sv
// Program-counter incrementer: pcOut = pcIn + STEP, plus a sticky wrap flag for debug.
// Build option PC_ADDER_1_REG_OUT_EN: when defined, pcOut and wrap are registered
// (one cycle of latency, reset to zero) and the sticky flag samples the registered wrap.
// When undefined, pcOut and wrap follow pcIn combinationally.
module pc_adder_1
  import pc_adder_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int STEP  = PC_STEP
) (
  input logic        clk,
  input logic        rst_n,
  pc_adder_1_if.slave bus
);

  logic [WIDTH-1:0] sumPc;
  logic             sumWrap;
  logic             wrapSrc;
  logic             wrap_seen_d;
  logic             wrap_seen_q;

  pc_adder_1_core #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_core (
    .pcIn_i  (bus.pcIn),
    .pcOut_o (sumPc),
    .wrap_o  (sumWrap)
  );

`ifdef PC_ADDER_1_REG_OUT_EN
  logic [WIDTH-1:0] pcOut_q;
  logic             wrap_q;

  // Output stage: capture the sum each edge; reset returns the PC and carry to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcOut_q <= WIDTH'(PC_RESET);
      wrap_q  <= 1'b0;
    end else begin
      pcOut_q <= sumPc;
      wrap_q  <= sumWrap;
    end
  end

  assign bus.pcOut = pcOut_q;
  assign bus.wrap  = wrap_q;
  assign wrapSrc   = wrap_q;
`else
  assign bus.pcOut = sumPc;
  assign bus.wrap  = sumWrap;
  assign wrapSrc   = sumWrap;
`endif

  // Sticky-flag next state: a clear beats a simultaneous wrap, otherwise a wrap sets it.
  always_comb begin
    wrap_seen_d = wrap_seen_q;
    if (bus.clr_wrap) begin
      wrap_seen_d = 1'b0;
    end else if (wrapSrc) begin
      wrap_seen_d = 1'b1;
    end
  end

  // Sticky-flag register; reset takes precedence so a garbage PC cannot set it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrap_seen_q <= 1'b0;
    end else begin
      wrap_seen_q <= wrap_seen_d;
    end
  end

  assign bus.wrap_seen = wrap_seen_q;

endmodule

// File: tb/tb_pc_adder_1.sv
// Self-checking bench for pc_adder_1 (STEP=1, WIDTH=16).
// Expected sums go into a scoreboard queue when a PC is driven and are popped when
// the output is due. Build with PC_ADDER_1_REG_OUT_EN to exercise the registered stage.
module tb_pc_adder_1;

  typedef struct {
    logic [15:0] pc;
    logic        w;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  exp_t sb[$];

  pc_adder_1_if #(.WIDTH(16)) bus ();

  pc_adder_1 #(.WIDTH(16), .STEP(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive a PC and push the expected sum and carry onto the scoreboard.
  task automatic applyStimulus(input logic [15:0] pc, input string name);
    logic [16:0] s;
    exp_t e;
    bus.pcIn = pc;
    s = {1'b0, pc} + 17'd1;
    e.pc = s[15:0];
    e.w = s[16];
    e.name = name;
    sb.push_back(e);
  endtask

  // Wait until the output for the last driven PC is due.
  task automatic waitOut();
`ifdef PC_ADDER_1_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    bus.clr_wrap = 1'b0;
    @(negedge clk);
    applyStimulus(16'h0000, "reset_pc0");
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (bus.wrap_seen !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_wrap_seen: got %b want 0", bus.wrap_seen);
    end
    e = sb.pop_front();
`ifdef PC_ADDER_1_REG_OUT_EN
    e.pc = 16'h0000;
    e.w = 1'b0;
`endif
    compared++;
    if (bus.pcOut !== e.pc || bus.wrap !== e.w) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h/%b want %h/%b", e.name, bus.pcOut, bus.wrap, e.pc, e.w);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [15:0] pcs[$];
    pcs = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'hFFFF, 16'hFFFE, 16'h8000};
    for (int i = 0; i < 16; i++) pcs.push_back(16'($urandom_range(0, 65535)));
    foreach (pcs[i]) begin
      @(negedge clk);
      applyStimulus(pcs[i], $sformatf("b2b_%0d", i));
      waitOut();
      e = sb.pop_front();
      compared++;
      if (bus.pcOut !== e.pc || bus.wrap !== e.w) begin
        mismatched++;
        $display("[TB] FAIL %s: pcIn=%h got %h/%b want %h/%b", e.name, pcs[i], bus.pcOut, bus.wrap, e.pc, e.w);
      end
    end
  endtask

`ifndef PC_ADDER_1_REG_OUT_EN
  task automatic test_increment();
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(16'(i), $sformatf("inc_%0d", i));
      #0;
      #1;
      e = sb.pop_front();
      compared++;
      if (bus.pcOut !== e.pc || bus.wrap !== e.w) begin
        mismatched++;
        $display("[TB] FAIL %s: got %h/%b want %h/%b", e.name, bus.pcOut, bus.wrap, e.pc, e.w);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    @(negedge clk);
    applyStimulus(16'hFFFF, "wrap_ffff");
    #1;
    e = sb.pop_front();
    compared++;
    if (bus.pcOut !== e.pc || bus.wrap !== e.w || e.w !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h/%b want %h/%b", e.name, bus.pcOut, bus.wrap, e.pc, e.w);
    end
    compared++;
    if (bus.wrap_seen !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL wrap_seen_before_edge: got %b want 0", bus.wrap_seen);
    end
    @(posedge clk);
    #1;
    compared++;
    if (bus.wrap_seen !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL wrap_seen_set: got %b want 1", bus.wrap_seen);
    end
    applyStimulus(16'h0005, "wrap_then5");
    #1;
    e = sb.pop_front();
    compared++;
    if (bus.pcOut !== e.pc || bus.wrap !== e.w) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h/%b want %h/%b", e.name, bus.pcOut, bus.wrap, e.pc, e.w);
    end
    @(posedge clk);
    #1;
    compared++;
    if (bus.wrap_seen !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL wrap_seen_hold: got %b want 1", bus.wrap_seen);
    end
  endtask

  task automatic test_clear();
    @(negedge clk);
    bus.pcIn = 16'hFFFF;
    bus.clr_wrap = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (bus.wrap_seen !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL clear_beats_wrap: got %b want 0", bus.wrap_seen);
    end
    @(negedge clk);
    bus.clr_wrap = 1'b0;
    @(posedge clk);
    #1;
    compared++;
    if (bus.wrap_seen !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_after_clear: got %b want 1", bus.wrap_seen);
    end
    @(negedge clk);
    bus.pcIn = 16'h0010;
    bus.clr_wrap = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (bus.wrap_seen !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL clear_alone: got %b want 0", bus.wrap_seen);
    end
    @(negedge clk);
    bus.clr_wrap = 1'b0;
  endtask

  task automatic test_mid_reset();
    exp_t e;
    @(negedge clk);
    bus.pcIn = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    applyStimulus(16'h0007, "midreset_pc7");
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    compared++;
    if (bus.wrap_seen !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midreset_wrap_seen: got %b want 0", bus.wrap_seen);
    end
    e = sb.pop_front();
    compared++;
    if (bus.pcOut !== e.pc || bus.wrap !== e.w) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h/%b want %h/%b", e.name, bus.pcOut, bus.wrap, e.pc, e.w);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`else
  task automatic test_reg_out();
    exp_t e;
    @(negedge clk);
    applyStimulus(16'h0003, "reg_pc3");
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compared++;
    if (bus.pcOut !== e.pc || bus.wrap !== e.w) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h/%b want %h/%b", e.name, bus.pcOut, bus.wrap, e.pc, e.w);
    end
    @(negedge clk);
    applyStimulus(16'hFFFF, "reg_ffff");
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compared++;
    if (bus.pcOut !== e.pc || bus.wrap !== e.w) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h/%b want %h/%b", e.name, bus.pcOut, bus.wrap, e.pc, e.w);
    end
    compared++;
    if (bus.wrap_seen !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reg_wrap_seen_lag: got %b want 0", bus.wrap_seen);
    end
    @(negedge clk);
    bus.pcIn = 16'h0003;
    @(posedge clk);
    #1;
    compared++;
    if (bus.wrap_seen !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reg_wrap_seen_set: got %b want 1", bus.wrap_seen);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    compared++;
    if (bus.pcOut !== 16'h0000 || bus.wrap !== 1'b0 || bus.wrap_seen !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reg_reset: got %h/%b/%b want 0000/0/0", bus.pcOut, bus.wrap, bus.wrap_seen);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  // Run every scenario in order, then report.
  initial begin
    compared = 0;
    mismatched = 0;
    bus.pcIn = 16'h0000;
    bus.clr_wrap = 1'b0;
    rst_n = 1'b0;
    test_reset();
`ifndef PC_ADDER_1_REG_OUT_EN
    test_increment();
    test_wrap();
    test_clear();
    test_mid_reset();
`else
    test_reg_out();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
